ldpc_enc: RTL

//  Systematic QC-LDPC encoder; the transmit-side counterpart of ldpc_core.

---
 rtl/ldpc_enc.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ldpc_enc.sv
// ldpc_enc: systematic QC-LDPC encoder for dual-diagonal (802.16e-style) codes.
// Accumulates lambda_i = sum_j P^h(i,j)(u_j) one info column per cycle, with C
// parallel barrel shifters. It then solves the first parity block p_0 and runs
// the dual-diagonal recursion for p_1..p_(C-1), one block per cycle.
//
// Ports:
//   clk     rising-edge clock
//   rst     synchronous active-high reset; overrides en and start
//   en      clock enable; 0 freezes all state
//   start   begin encoding; accepted in IDLE or DONE
//   u       (R-C)*D message bits, block 0 at MSBs
//   m       C*R signed data_w-bit base matrix entries, row-major, (0,0) at MSBs
//   c       R*D codeword {u, p_0 .. p_(C-1)}, block 0 at MSBs
//   status  [0] done, [1] error
//
// Optional feature: define LDPC_ENC_SELFCHECK_EN to check row C-1 of H in the
// last parity cycle. A nonzero result flags status[1] along with done.
module ldpc_enc #(
    parameter int C      = 12,
    parameter int R      = 24,
    parameter int D      = 96,
    parameter int data_w = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  start,
    input  logic [(R-C)*D-1:0]    u,
    input  logic [C*R*data_w-1:0] m,
    output logic [R*D-1:0]        c,
    output logic [1:0]            status
);
    localparam int unsigned KB    = R - C;
    localparam int unsigned DU    = D;
    localparam int unsigned CNT_W = $clog2(R);
    localparam int unsigned ROW_W = $clog2(C);
    localparam logic signed [data_w-1:0] NEG1 = '1;

    typedef enum logic [2:0] {IDLE, ACC, P0, PAR, DONE} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [D-1:0]       lambda [C];
    logic [D-1:0]       p0;
    logic [D-1:0]       pcur;

    logic signed [data_w-1:0] h [C][R];
    logic [D-1:0]       u_cur;
    logic [D-1:0]       lam_nxt [C];
    logic [D-1:0]       p0_c;
    logic [D-1:0]       par_nxt;
    logic signed [data_w-1:0] h_par;
    logic [ROW_W-1:0]   row;
    logic               col_ok;
    logic               acc_last;
    logic               par_last;
    logic               chk_err;

    // P^s(x)[k] = x[(k+s) mod D]: a right rotation by s of the doubled word
    function automatic logic [D-1:0] rot(input logic [D-1:0] x, input logic [data_w-1:0] e);
        logic [2*D-1:0] xx;
        int unsigned    s;
        s  = 32'(e) % DU;
        xx = {x, x} >> s;
        return xx[D-1:0];
    endfunction

    // Unpack the base matrix into signed entries
    always_comb begin : unpack_m
        for (int i = 0; i < C; i++) begin
            for (int j = 0; j < R; j++) begin
                h[i][j] = m[(C*R-1-(i*R+j))*data_w +: data_w];
            end
        end
    end

    assign acc_last = (cnt == CNT_W'(KB-1));
    assign par_last = (cnt == CNT_W'(C-2));
    assign row      = cnt[ROW_W-1:0];

    // Info-column accumulation: one shifter per row
    always_comb begin : acc_c
        u_cur = c[(R-1-int'(cnt))*D +: D];
        for (int i = 0; i < C; i++) begin
            lam_nxt[i] = lambda[i];
            if (!h[i][cnt][data_w-1]) begin
                lam_nxt[i] = lambda[i] ^ rot(u_cur, h[i][cnt]);
            end
        end
    end

    // Column K_b must be {x, one 0 in the middle, x} with -1 elsewhere
    always_comb begin : col_check
        int unsigned nz;
        logic        bad;
        nz  = 0;
        bad = 1'b0;
        for (int i = 1; i < C-1; i++) begin
            if (h[i][KB] == '0) begin
                nz++;
            end else if (h[i][KB] != NEG1) begin
                bad = 1'b1;
            end
        end
        col_ok = !h[0][KB][data_w-1] && (h[0][KB] == h[C-1][KB]) && (nz == 1) && !bad;
    end

    // Summing all rows cancels the dual diagonal, leaving p_0 = XOR of lambda
    always_comb begin : p0_sum
        p0_c = '0;
        for (int i = 0; i < C; i++) begin
            p0_c = p0_c ^ lambda[i];
        end
    end

    // Dual-diagonal recursion; pcur is zero on the first step
    always_comb begin : par_c
        h_par   = h[row][KB];
        par_nxt = pcur ^ lambda[row];
        if (!h_par[data_w-1]) begin
            par_nxt = par_nxt ^ rot(p0, h_par);
        end
`ifdef LDPC_ENC_SELFCHECK_EN
        chk_err = |(lambda[C-1] ^ rot(p0, h[0][KB]) ^ par_nxt);
`else
        chk_err = 1'b0;
`endif
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else if (en) begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin : fsm_c
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = ACC;
            ACC:        if (acc_last) state_nxt = P0;
            P0:         state_nxt = col_ok ? PAR : DONE;
            PAR:        if (par_last) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            c      <= '0;
            status <= 2'b00;
            p0     <= '0;
            pcur   <= '0;
            cnt    <= '0;
            for (int i = 0; i < C; i++) lambda[i] <= '0;
        end else if (en) begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        c      <= {u, {(C*D){1'b0}}};
                        status <= 2'b00;
                        p0     <= '0;
                        pcur   <= '0;
                        cnt    <= '0;
                        for (int i = 0; i < C; i++) lambda[i] <= '0;
                    end
                end
                ACC: begin
                    for (int i = 0; i < C; i++) lambda[i] <= lam_nxt[i];
                    cnt <= acc_last ? '0 : cnt + 1'b1;
                end
                P0: begin
                    cnt  <= '0;
                    pcur <= '0;
                    if (col_ok) begin
                        p0                  <= p0_c;
                        c[(C-1)*D +: D]     <= p0_c;
                    end else begin
                        status <= 2'b11;
                    end
                end
                PAR: begin
                    pcur                         <= par_nxt;
                    c[(C-2-int'(cnt))*D +: D]    <= par_nxt;
                    cnt                          <= cnt + 1'b1;
                    if (par_last) begin
                        status <= {chk_err, 1'b1};
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
